// File: rtl/bpred_gshare_btb.sv
// Fetch-stage predictor: 2-bit-counter PHT plus tagged direct-mapped BTB, same-cycle lookup.
// Define BPRED_GSHARE_EN for gshare indexing with a speculative, repairable global history.
module bpred_gshare_btb #(
  parameter int PC_W      = 32,
  parameter int PHT_IDX_W = 10,
  parameter int BTB_IDX_W = 6,
  parameter int BTB_TAG_W = 12,
  parameter int GHR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              if_allowin_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  output logic [1:0]        pred_state_o,
  output logic              btb_hit_o,
  output logic [PC_W-1:0]   pred_target_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic [1:0]        upd_state_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  input  logic              upd_mispredict_i
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  logic [1:0]           pht       [PHT_N];
  logic                 btb_valid [BTB_N];
  logic [BTB_TAG_W-1:0] btb_tag   [BTB_N];
  logic [PC_W-1:0]      btb_tgt   [BTB_N];

  logic [PHT_IDX_W-1:0] lk_hist, upd_hist, lk_pht_idx, upd_pht_idx;
  logic [BTB_IDX_W-1:0] lk_btb_idx, upd_btb_idx;
  logic [BTB_TAG_W-1:0] lk_tag, upd_tag;
  logic [1:0]           upd_next;
  logic                 unused_bits;

  assign lk_pht_idx  = pc_i[PHT_IDX_W+1:2] ^ lk_hist;
  assign lk_btb_idx  = pc_i[BTB_IDX_W+1:2];
  assign lk_tag      = pc_i[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
  assign upd_pht_idx = upd_pc_i[PHT_IDX_W+1:2] ^ upd_hist;
  assign upd_btb_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag     = upd_pc_i[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];

  assign btb_hit_o     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
  assign pred_state_o  = pht[lk_pht_idx];
  assign pred_taken_o  = btb_hit_o && pred_state_o[1];
  assign pred_target_o = pred_taken_o ? btb_tgt[lk_btb_idx] : pc_i + PC_W'(4);

  // Counter steps from the state captured at prediction time; the table is not re-read.
  always_comb begin
    upd_next = upd_state_i;
    if (upd_taken_i) begin
      if (upd_state_i != 2'b11) upd_next = upd_state_i + 2'b01;
    end else begin
      if (upd_state_i != 2'b00) upd_next = upd_state_i - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_o <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      for (int j = 0; j < BTB_N; j++) btb_valid[j] <= 1'b0;
    end else begin
      pred_valid_o <= if_allowin_i;
      if (upd_valid_i) pht[upd_pht_idx] <= upd_next;
      if (upd_valid_i && upd_taken_i) btb_valid[upd_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && upd_valid_i && upd_taken_i) begin
      btb_tag[upd_btb_idx] <= upd_tag;
      btb_tgt[upd_btb_idx] <= upd_target_i;
    end
  end

`ifdef BPRED_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign lk_hist    = PHT_IDX_W'(ghr);
  assign upd_hist   = PHT_IDX_W'(upd_ghr_i);
  assign pred_ghr_o = ghr;

  // Repair from the resolved snapshot overrides any speculative shift in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_valid_i && upd_mispredict_i) begin
      ghr <= {upd_ghr_i[GHR_W-2:0], upd_taken_i};
    end else if (if_allowin_i && btb_hit_o) begin
      ghr <= {ghr[GHR_W-2:0], pred_taken_o};
    end
  end

  assign unused_bits = &{1'b0, pc_i, upd_pc_i};
`else
  assign lk_hist     = '0;
  assign upd_hist    = '0;
  assign pred_ghr_o  = '0;
  assign unused_bits = &{1'b0, pc_i, upd_pc_i, upd_ghr_i, upd_mispredict_i};
`endif

endmodule

// File: tb/tb_bpred_gshare_btb.sv
// Bench for bpred_gshare_btb: table-level reference model checked every cycle, plus literal checks.
module tb_bpred_gshare_btb;
`ifdef BPRED_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        allowin;
  logic        pred_valid, pred_taken, btb_hit;
  logic [1:0]  pred_state;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_valid, upd_taken, upd_mis;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_state;
  logic [7:0]  upd_ghr;

  int total = 0;
  int bad   = 0;

  bpred_gshare_btb dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .if_allowin_i(allowin),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_state_o(pred_state),
    .btb_hit_o(btb_hit), .pred_target_o(pred_target), .pred_ghr_o(pred_ghr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_state_i(upd_state), .upd_ghr_i(upd_ghr),
    .upd_mispredict_i(upd_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain tables and integer arithmetic
  int          m_pht [1024];
  bit          m_v   [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ghr;
  bit          m_pv;
  bit          model_ok = 1'b0;

  function automatic int pidx(input logic [31:0] a, input int h);
    return ((a >> 2) % 1024) ^ (GSHARE ? h : 0);
  endfunction

  always @(negedge clk) begin
    int          bi, st;
    bit          hit, tk;
    logic [31:0] tgt;
    bi  = (pc >> 2) % 64;
    hit = m_v[bi] && (m_tag[bi] == int'((pc >> 8) % 4096));
    st  = m_pht[pidx(pc, m_ghr)];
    tk  = hit && (st >= 2);
    tgt = tk ? m_tgt[bi] : pc + 32'd4;
    if (model_ok) begin
      chk("pred_valid", pred_valid, m_pv);
      chk("btb_hit", btb_hit, hit);
      chk("pred_state", pred_state, st);
      chk("pred_taken", pred_taken, tk);
      chk("pred_target", pred_target, tgt);
      chk("pred_ghr", pred_ghr, m_ghr);
    end
    // Advance the model with the inputs the next rising edge will see.
    if (!rst_n) begin
      foreach (m_pht[i]) m_pht[i] = 1;
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_ghr = 0; m_pv = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      m_pv = allowin;
      if (upd_valid) begin
        int ui;
        ui = pidx(upd_pc, upd_ghr);
        m_pht[ui] = upd_taken ? (upd_state == 3 ? 3 : upd_state + 1)
                              : (upd_state == 0 ? 0 : upd_state - 1);
        if (upd_taken) begin
          m_v[(upd_pc >> 2) % 64]   = 1'b1;
          m_tag[(upd_pc >> 2) % 64] = (upd_pc >> 8) % 4096;
          m_tgt[(upd_pc >> 2) % 64] = upd_target;
        end
      end
      if (GSHARE) begin
        if (upd_valid && upd_mis) m_ghr = ((upd_ghr << 1) | upd_taken) % 256;
        else if (allowin && hit)  m_ghr = ((m_ghr << 1) | tk) % 256;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mis = 1'b0; allowin = 1'b0;
  endtask

  task automatic send_upd(input logic [31:0] a, input bit t, input logic [31:0] tg,
                          input logic [1:0] s, input logic [7:0] g, input bit mis);
    upd_valid = 1'b1; upd_pc = a; upd_taken = t; upd_target = tg;
    upd_state = s; upd_ghr = g; upd_mis = mis;
  endtask

  initial begin
    logic [7:0] g;
    logic [31:0] pcs [4];
    rst_n = 1'b0; pc = 32'h1C00_0000; allowin = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_state = 2'b00; upd_ghr = '0; upd_mis = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Out of reset: miss, weak-NT, fall-through
    rst_n = 1'b1; pc = 32'h1C00_0000; allowin = 1'b1;
    #1;
    chk("lit_reset_hit", btb_hit, 0);
    chk("lit_reset_taken", pred_taken, 0);
    chk("lit_reset_state", pred_state, 2'b01);
    chk("lit_reset_target", pred_target, 32'h1C00_0004);
    chk("lit_reset_pvalid", pred_valid, 0);
    next_cycle();
    #1;
    chk("lit_pvalid_next", pred_valid, 1);

    // Train; a same-cycle lookup still sees the old contents
    next_cycle();
    pc = 32'h1C00_0010;
    send_upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 2'b01, 8'h00, 1'b0);
    #1;
    chk("lit_wr_same_cycle_hit", btb_hit, 0);
    next_cycle();
    pc = 32'h1C00_0010; allowin = 1'b1;
    #1;
    chk("lit_train_hit", btb_hit, 1);
    chk("lit_train_state", pred_state, 2'b10);
    chk("lit_train_taken", pred_taken, 1);
    chk("lit_train_target", pred_target, 32'h1C00_0100);
    next_cycle();
    #1;
    chk("lit_ghr_shift", pred_ghr, GSHARE ? 8'h01 : 8'h00);
    g = GSHARE ? 8'h01 : 8'h00;

    // Saturation at both ends, checked at the same index and history
    send_upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 2'b11, g, 1'b0);
    next_cycle();
    #1;
    chk("lit_sat_high", pred_state, 2'b11);
    send_upd(32'h1C00_0010, 1'b0, 32'h0, 2'b00, g, 1'b0);
    next_cycle();
    #1;
    chk("lit_sat_low", pred_state, 2'b00);
    chk("lit_nt_keeps_btb", btb_hit, 1);
    chk("lit_nt_target", pred_target, 32'h1C00_0014);

    // Alias: same BTB slot, different tag
    pc = 32'h1C01_0010;
    #1;
    chk("lit_alias_hit", btb_hit, 0);
    chk("lit_alias_target", pred_target, 32'h1C01_0014);

    // Repair beats a same-cycle speculative shift
    pc = 32'h1C00_0010;
    send_upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 2'b01, g, 1'b0);
    next_cycle();
    pc = 32'h1C00_0010; allowin = 1'b1;
    send_upd(32'h1C00_0040, 1'b1, 32'h1C00_0200, 2'b01, 8'h5A, 1'b1);
    #1;
    chk("lit_repair_lookup_taken", pred_taken, 1);
    next_cycle();
    #1;
    chk("lit_repair_ghr", pred_ghr, GSHARE ? 8'hB5 : 8'h00);

    // One-cycle reset; an update offered during it is dropped
    rst_n = 1'b0;
    send_upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 2'b10, 8'h00, 1'b0);
    next_cycle();
    rst_n = 1'b1; pc = 32'h1C00_0010;
    #1;
    chk("lit_rst_hit", btb_hit, 0);
    chk("lit_rst_state", pred_state, 2'b01);
    chk("lit_rst_ghr", pred_ghr, 0);

    // Mixed traffic over a small PC set, checked by the model each cycle
    pcs[0] = 32'h1C00_0010; pcs[1] = 32'h1C00_0020;
    pcs[2] = 32'h1C01_0010; pcs[3] = 32'h2000_0FFC;
    for (int k = 0; k < 80; k++) begin
      next_cycle();
      pc = pcs[$urandom_range(0, 3)];
      allowin = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        send_upd(pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), $urandom,
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    next_cycle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bpred_gshare_btb.md
Name: bpred_gshare_btb

Overview:
Second-generation fetch-stage branch predictor. It combines a parametrised 2-bit-counter PHT, indexed by PC XOR speculative global history (gshare), with a parametrised tagged direct-mapped BTB. It gives preIF/IF a same-cycle taken/target prediction. It takes back ID/EX resolution updates, including history repair on mispredict.

Parameters:
PC_W, 32, PC / target width
PHT_IDX_W, 10, log2 PHT entries
BTB_IDX_W, 6, log2 BTB entries
BTB_TAG_W, 12, BTB tag width (PC bits above the index)
GHR_W, 8, global history length; must be ≤ PHT_IDX_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
pc_i  in  PC_W  PC to predict
if_allowin_i  in  1  IF accepts this prediction
pred_valid_o  out  1  registered: prediction accepted last cycle
pred_taken_o  out  1  predicted taken
pred_state_o  out  2  PHT counter read (carried down pipe)
btb_hit_o  out  1  BTB valid and tag match
pred_target_o  out  PC_W  next fetch PC
pred_ghr_o  out  GHR_W  GHR snapshot used for this lookup (carried down pipe)
upd_valid_i  in  1  resolved branch update
upd_pc_i  in  PC_W  resolved branch PC
upd_taken_i  in  1  actual direction
upd_target_i  in  PC_W  actual taken target
upd_state_i  in  2  pred_state_o captured at prediction
upd_ghr_i  in  GHR_W  pred_ghr_o captured at prediction
upd_mispredict_i  in  1  direction or target mispredicted

Behaviour:
- Lookup is combinational from pc_i, with no read latency.
- pht_idx = pc_i[PHT_IDX_W+1:2] XOR {zero-pad, ghr}.
- btb_idx = pc_i[BTB_IDX_W+1:2].
- tag = pc_i[BTB_IDX_W+BTB_TAG_W+1 : BTB_IDX_W+2].
- btb_hit_o = valid[btb_idx] & (tag match).
- pred_state_o = pht[pht_idx].
- pred_taken_o = btb_hit_o & pred_state_o[1].
- pred_target_o = pred_taken_o ? btb_target[btb_idx] : pc_i + 4. Addition is modulo 2^PC_W.
- pred_ghr_o = current ghr.
- PHT encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset: all PHT entries 01; all BTB valid bits 0; ghr 0; pred_valid_o 0. Tags and targets are don't-care.
- pred_valid_o: the register loads if_allowin_i every cycle (1 the cycle after acceptance, 0 otherwise).
- Speculative GHR: when if_allowin_i & btb_hit_o, ghr <= {ghr[GHR_W-2:0], pred_taken_o}. Otherwise ghr holds.
- Repair: when upd_valid_i & upd_mispredict_i, ghr <= {upd_ghr_i[GHR_W-2:0], upd_taken_i}. Repair has priority over a same-cycle speculative shift.
- PHT update, when upd_valid_i:
  - Index = upd_pc_i[PHT_IDX_W+1:2] XOR upd_ghr_i.
  - New value = saturating step of upd_state_i: +1 if taken, capped at 11; −1 if not taken, floored at 00.
  - The table is not re-read.
- BTB update, when upd_valid_i & upd_taken_i: valid=1, tag and target written at upd_pc_i's index; overwrites any alias.
- A not-taken update leaves the BTB untouched.
- Write/read same entry in the same cycle: the lookup returns the old contents; the new value is visible the next cycle.
- Reset asserted mid-operation reinitialises all state in the same edge. Updates presented during reset are dropped.

Optional Feature:
BPRED_GSHARE_EN — when defined: gshare indexing, GHR register, and repair logic exactly as above. When undefined: pht_idx = PC bits only (both lookup and update), no GHR flops, pred_ghr_o tied 0, upd_ghr_i ignored. All other behaviour is identical.

Test Plan:
- Reset, then pc_i=0x1C000000 with allowin=1 → btb_hit_o=0, pred_taken_o=0, pred_state_o=01, pred_target_o=0x1C000004. pred_valid_o=0 during the lookup cycle, 1 the next cycle.
- Update pc=0x1C000010, taken=1, target=0x1C000100, state=01, ghr=0, mispredict=0 → next cycle, lookup 0x1C000010 (ghr still 0) gives hit=1, state=10, taken=1, target=0x1C000100. With allowin=1, pred_ghr_o=0x01 the following cycle.
- Saturation: update with state=11, taken=1 → entry stays 11. Update with state=00, taken=0 → entry stays 00. Check both by re-lookup at the same index and ghr.
- Repair: upd_ghr_i=0x5A, taken=1, mispredict=1 in the same cycle as a predicted-taken lookup with allowin=1 → pred_ghr_o=0xB5 the next cycle (repair wins).
- Alias: after training 0x1C000010, lookup 0x1C010010 (same index, different tag) → btb_hit_o=0, target=0x1C010014.
- Reset asserted for one cycle after training → previously trained PC misses and state reads 01.
